paddle_ctrl: RTL and testbench

- Second-generation Pong paddle: vertical paddle position, rendering and ball-contact zoning in a single `clk` domain.
- Replaces vsync-clocked position logic with a frame tick derived from `vsync` inside `clk`.
- Adds parametrised geometry, speed ramping while a button is held, and an optional AI mode that tracks the ball.
- Sits between the button inputs/ball block and the VGA pixel mux; one instance per player.

---
 rtl/pong_pkg.sv | 27 ++
 rtl/paddle_ctrl_if.sv | 15 +
 rtl/paddle_ctrl_sync_edge.sv | 30 +++
 rtl/paddle_ctrl.sv | 141 ++++++++++++++
 tb/tb_paddle_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared Pong definitions: screen geometry, coordinate types, paddle state
// and contact-zone encodings, plus the clamped paddle move helper.
package pong_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COORD_W  = 10;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   coord11_t;

  typedef enum logic [1:0] {IDLE, UP, DOWN, AI} pad_state_e;
  typedef enum logic [1:0] {ZONE_TOP, ZONE_UPPER, ZONE_LOWER, ZONE_BOT} zone_e;

  // 11-bit move with saturation at the travel limits; never wraps.
  function automatic coord_t move_clamp(input coord_t y, input coord11_t step,
                                        input logic up, input coord11_t top,
                                        input coord11_t bot);
    coord11_t y11;
    y11 = {1'b0, y};
    if (up) begin
      if (y11 <= top + step) return coord_t'(top);
      return coord_t'(y11 - step);
    end
    if (y11 + step >= bot) return coord_t'(bot);
    return coord_t'(y11 + step);
  endfunction
endpackage

// File: rtl/paddle_ctrl_if.sv
// Paddle I/O bundle: frame/button/ball/raster inputs and the paddle's
// position, contact-zone and pixel outputs.
interface paddle_ctrl_if;
  import pong_pkg::*;
  logic       vsync, up_n, down_n, ai_en;
  coord_t     ball_y, hcount, vcount;
  coord_t     paddle_y;
  logic [1:0] hit_zone;
  logic       hit_valid, r, g, b;

  modport master (output vsync, up_n, down_n, ai_en, ball_y, hcount, vcount,
                  input  paddle_y, hit_zone, hit_valid, r, g, b);
  modport slave  (input  vsync, up_n, down_n, ai_en, ball_y, hcount, vcount,
                  output paddle_y, hit_zone, hit_valid, r, g, b);
endinterface

// File: rtl/paddle_ctrl_sync_edge.sv
// Two-flop synchroniser for an idle-high input plus a one-cycle pulse on
// the synchronised 1->0 transition.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic fall_o
);
  logic [1:0] sync_q, sync_d;
  logic       hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[0], d_i};
    hist_d = sync_q[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      hist_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign q_o    = sync_q[1];
  assign fall_o = hist_q & ~sync_q[1];
endmodule

// File: rtl/paddle_ctrl.sv
// Pong paddle: frame-ticked position with speed ramp or ball-tracking AI,
// registered paddle pixel and ball contact zoning.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int PLAYER      = 0,
  parameter int X_LEFT      = 12,
  parameter int PAD_W       = 10,
  parameter int PAD_H       = 48,
  parameter int TOP_LIM     = 10,
  parameter int BOT_LIM     = 421,
  parameter int START_Y     = 216,
  parameter int SPEED_MIN   = 2,
  parameter int SPEED_MAX   = 8,
  parameter int RAMP_FRAMES = 4,
  parameter int AI_SPEED    = 4,
  parameter int AI_DEADBAND = 6
) (
  input logic         clk,
  input logic         rst,
  paddle_ctrl_if.slave bus
);
  localparam int       X_COL    = (PLAYER == 0) ? X_LEFT : (H_ACTIVE - 1 - X_LEFT - 10);
  localparam coord11_t COL_LO   = coord11_t'(X_COL + 1);
  localparam coord11_t COL_HI   = coord11_t'(X_COL + PAD_W - 1);
  localparam coord11_t FULL_H   = coord11_t'(PAD_H);
  localparam coord11_t HALF_H   = coord11_t'(PAD_H / 2);
  localparam coord11_t ZONE_1   = coord11_t'(PAD_H / 4);
  localparam coord11_t ZONE_2   = coord11_t'(2 * (PAD_H / 4));
  localparam coord11_t ZONE_3   = coord11_t'(3 * (PAD_H / 4));
  localparam coord11_t TOP      = coord11_t'(TOP_LIM);
  localparam coord11_t BOT      = coord11_t'(BOT_LIM);
  localparam coord11_t AI_STEP  = coord11_t'(AI_SPEED);
  localparam logic [7:0] SPD_MIN = 8'(SPEED_MIN);
  localparam logic [7:0] SPD_MAX = 8'(SPEED_MAX);
  localparam logic [7:0] RAMP_N  = 8'(RAMP_FRAMES);
  localparam logic signed [10:0] DEADBAND = 11'(AI_DEADBAND);

  logic up_s, dn_s, vs_s, frame_tick, up_fall, dn_fall;

  sync_edge u_sync_up (.clk(clk), .rst(rst), .d_i(bus.up_n),   .q_o(up_s), .fall_o(up_fall));
  sync_edge u_sync_dn (.clk(clk), .rst(rst), .d_i(bus.down_n), .q_o(dn_s), .fall_o(dn_fall));
  sync_edge u_sync_vs (.clk(clk), .rst(rst), .d_i(bus.vsync),  .q_o(vs_s), .fall_o(frame_tick));

  // Button edges are not needed; only levels steer the paddle.
  logic unused_sync;
  assign unused_sync = ^{up_fall, dn_fall, vs_s};

  pad_state_e state_q, state_d, nxt_state;
  logic [7:0] speed_q, speed_d, ramp_q, ramp_d;
  coord_t     y_q, y_d;
  logic       pix_q, pix_d, hit_valid_q, hit_valid_d;
  zone_e      hit_zone_q, hit_zone_d;

  coord11_t y11, ybot11, ball11, h11, v11, dist11;
  logic signed [10:0] err;

  assign y11    = {1'b0, y_q};
  assign ybot11 = y11 + FULL_H;
  assign ball11 = {1'b0, bus.ball_y};
  assign h11    = {1'b0, bus.hcount};
  assign v11    = {1'b0, bus.vcount};
  assign dist11 = ball11 - y11;
  assign err    = $signed(ball11 - (y11 + HALF_H));

  always_comb begin
    nxt_state = IDLE;
    if (bus.ai_en)        nxt_state = AI;
    else if (!up_s && dn_s) nxt_state = UP;
    else if (!dn_s && up_s) nxt_state = DOWN;
  end

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    ramp_d  = ramp_q;
    y_d     = y_q;
    if (frame_tick) begin
      state_d = nxt_state;
      speed_d = SPD_MIN;
      ramp_d  = '0;
      // Holding the same direction ramps speed; any other transition restarts it.
      if ((nxt_state == UP || nxt_state == DOWN) && nxt_state == state_q) begin
        if (ramp_q + 8'd1 == RAMP_N) begin
          ramp_d  = '0;
          speed_d = (speed_q >= SPD_MAX) ? SPD_MAX : speed_q + 8'd1;
        end else begin
          ramp_d  = ramp_q + 8'd1;
          speed_d = speed_q;
        end
      end
      case (nxt_state)
        UP:   y_d = move_clamp(y_q, coord11_t'(speed_d), 1'b1, TOP, BOT);
        DOWN: y_d = move_clamp(y_q, coord11_t'(speed_d), 1'b0, TOP, BOT);
        AI: begin
          if (err < -DEADBAND)     y_d = move_clamp(y_q, AI_STEP, 1'b1, TOP, BOT);
          else if (err > DEADBAND) y_d = move_clamp(y_q, AI_STEP, 1'b0, TOP, BOT);
        end
        default: y_d = y_q;
      endcase
    end
  end

  always_comb begin
    pix_d       = (h11 >= COL_LO) && (h11 <= COL_HI) && (v11 >= y11) && (v11 <= ybot11);
    hit_valid_d = (ball11 >= y11) && (ball11 <= ybot11);
    hit_zone_d  = ZONE_TOP;
    if (hit_valid_d) begin
      if (dist11 >= ZONE_3)      hit_zone_d = ZONE_BOT;
      else if (dist11 >= ZONE_2) hit_zone_d = ZONE_LOWER;
      else if (dist11 >= ZONE_1) hit_zone_d = ZONE_UPPER;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      speed_q     <= SPD_MIN;
      ramp_q      <= '0;
      y_q         <= coord_t'(START_Y);
      pix_q       <= 1'b0;
      hit_valid_q <= 1'b0;
      hit_zone_q  <= ZONE_TOP;
    end else begin
      state_q     <= state_d;
      speed_q     <= speed_d;
      ramp_q      <= ramp_d;
      y_q         <= y_d;
      pix_q       <= pix_d;
      hit_valid_q <= hit_valid_d;
      hit_zone_q  <= hit_zone_d;
    end
  end

  assign bus.paddle_y  = y_q;
  assign bus.hit_valid = hit_valid_q;
  assign bus.hit_zone  = hit_zone_q;
  assign bus.r         = pix_q;
  assign bus.g         = pix_q;
  assign bus.b         = pix_q;
endmodule

// File: tb/tb_paddle_ctrl.sv
// Scoreboard bench for paddle_ctrl: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_paddle_ctrl;
  import pong_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  paddle_ctrl_if pif();
  paddle_ctrl #(.PLAYER(0)) dut (.clk(clk), .rst(rst), .bus(pif));

  typedef struct {
    int    sel;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  int up_tab[10] = '{214, 212, 210, 208, 205, 202, 199, 196, 192, 188};
  int dn_tab[41] = '{190, 192, 194, 196, 199, 202, 205, 208, 212, 216,
                     220, 224, 229, 234, 239, 244, 250, 256, 262, 268,
                     275, 282, 289, 296, 304, 312, 320, 328, 336, 344,
                     352, 360, 368, 376, 384, 392, 400, 408, 416, 421, 421};
  int px_h[6]   = '{13, 22, 13, 12, 21, 13};
  int px_v[6]   = '{216, 216, 265, 216, 264, 215};
  int px_e[6]   = '{7, 0, 0, 0, 7, 0};
  int bl_y[10]  = '{216, 239, 264, 265, 215, 240, 227, 228, 251, 252};
  int bl_v[10]  = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
  int bl_z[10]  = '{0, 1, 3, 0, 0, 2, 0, 1, 2, 3};

  function automatic int act_of(input int sel);
    case (sel)
      0:       return int'(pif.paddle_y);
      1:       return int'({pif.r, pif.g, pif.b});
      2:       return int'(pif.hit_valid);
      3:       return int'(pif.hit_zone);
      default: return -1;
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    int   a;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = act_of(e.sel);
      n_chk++;
      if (a != e.val) begin
        n_fail++;
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", e.name, a, e.val, $time);
      end
    end
  end

  task automatic expect_val(input int sel, input int val, input string name);
    exp_t e;
    e.sel = sel; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    cyc(2);
    pif.vsync = 1'b0;
    cyc(4);
    pif.vsync = 1'b1;
    cyc(3);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    cyc(n);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    pif.vsync = 1'b1; pif.up_n = 1'b1; pif.down_n = 1'b1; pif.ai_en = 1'b0;
    pif.ball_y = 10'd220; pif.hcount = 10'd13; pif.vcount = 10'd216;
    cyc(3);
    expect_val(1, 0, "rst_rgb");
    expect_val(2, 0, "rst_hit_valid");
    expect_val(0, 216, "rst_paddle_y");
    rst = 1'b0;
    cyc(1);
    expect_val(1, 7, "post_rst_rgb");
    expect_val(2, 1, "post_rst_hit_valid");

    pif.ball_y = 10'd100;
    for (int i = 0; i < 3; i++) begin
      frame();
      expect_val(0, 216, "idle_y");
      expect_val(2, 0, "idle_hit_valid");
    end

    pif.up_n = 1'b0; pif.down_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      frame();
      expect_val(0, 216, "both_y");
    end

    pif.down_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      frame();
      expect_val(0, up_tab[i], "up_ramp_y");
    end
    pif.up_n = 1'b1;
    frame();
    expect_val(0, 188, "release_y");

    pif.down_n = 1'b0;
    for (int i = 0; i < 41; i++) begin
      frame();
      expect_val(0, dn_tab[i], "down_ramp_y");
    end
    pif.down_n = 1'b1;

    pif.ai_en = 1'b1; pif.ball_y = 10'd0;
    for (int k = 1; k <= 104; k++) begin
      frame();
      expect_val(0, (k <= 102) ? 421 - 4 * k : 10, "ai_up_clamp_y");
    end
    pif.ai_en = 1'b0; pif.up_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      frame();
      expect_val(0, 10, "top_hold_y");
    end
    pif.up_n = 1'b1;

    pif.vsync = 1'b0;
    cyc(1);
    do_reset(2);
    pif.vsync = 1'b1;
    expect_val(0, 216, "mid_frame_rst_y");
    pif.up_n = 1'b0;
    cyc(8);
    expect_val(0, 216, "no_tick_after_rst_y");
    frame();
    expect_val(0, 214, "first_move_after_rst_y");
    pif.up_n = 1'b1;
    do_reset(2);

    pif.ai_en = 1'b1; pif.ball_y = 10'd400;
    for (int i = 1; i <= 5; i++) begin
      frame();
      expect_val(0, 216 + 4 * i, "ai_track_y");
    end
    pif.ball_y = 10'd266; frame(); expect_val(0, 236, "ai_db_pos_hold");
    pif.ball_y = 10'd267; frame(); expect_val(0, 240, "ai_db_pos_move");
    pif.ball_y = 10'd258; frame(); expect_val(0, 240, "ai_db_neg_hold");
    pif.ball_y = 10'd257; frame(); expect_val(0, 236, "ai_db_neg_move");
    pif.ai_en = 1'b0; pif.up_n = 1'b0;
    frame();
    expect_val(0, 234, "ai_exit_up_y");
    pif.up_n = 1'b1;

    do_reset(2);
    pif.ai_en = 1'b1; pif.ball_y = 10'd240;
    frame();
    expect_val(0, 216, "ai_centered_y");
    pif.ai_en = 1'b0;

    for (int i = 0; i < 6; i++) begin
      pif.hcount = 10'(px_h[i]);
      pif.vcount = 10'(px_v[i]);
      cyc(1);
      expect_val(1, px_e[i], "pixel_rgb");
    end
    for (int i = 0; i < 10; i++) begin
      pif.ball_y = 10'(bl_y[i]);
      cyc(1);
      expect_val(2, bl_v[i], "zone_hit_valid");
      expect_val(3, bl_z[i], "zone_hit_zone");
    end

    cyc(2);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
